// File: rtl/dot_product_stream_engine_if.sv
// dot_product_stream_engine_if: command, element stream and result handshake bundle
interface dot_product_stream_engine_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int CNT_WIDTH    = 3,
  parameter int RESULT_WIDTH = 18
);
  logic                    start;
  logic                    busy;
  logic                    start_reading;
  logic                    data_valid;
  logic [DATA_WIDTH-1:0]   mem1_output;
  logic [DATA_WIDTH-1:0]   mem2_output;
  logic [CNT_WIDTH-1:0]    element_count;
  logic                    reading_done;
  logic [RESULT_WIDTH-1:0] result;
  logic                    result_valid;
  logic                    result_ready;
  logic                    length_err;
  logic                    timeout_err;
  modport slave (
    input  start, data_valid, mem1_output, mem2_output, element_count, reading_done, result_ready,
    output busy, start_reading, result, result_valid, length_err, timeout_err
  );
  modport master (
    output start, data_valid, mem1_output, mem2_output, element_count, reading_done, result_ready,
    input  busy, start_reading, result, result_valid, length_err, timeout_err
  );
endinterface

// File: rtl/dot_product_stream_engine.sv
// dot_product_stream_engine: accumulates a streamed unsigned dot product and returns it over valid/ready
module dot_product_stream_engine #(
  parameter int DATA_WIDTH     = 8,
  parameter int VECTOR_WIDTH   = 4,
  parameter int CNT_WIDTH      = 3,
  parameter int RESULT_WIDTH   = 18,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst_n,
  dot_product_stream_engine_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] VW = CNT_WIDTH'(VECTOR_WIDTH);
  typedef enum logic [1:0] {IDLE, REQ, ACCUM, DONE} state_t;
  state_t                  state;
  logic [RESULT_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [TW-1:0]           timer;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [RESULT_WIDTH-1:0] acc_next;
  logic [CNT_WIDTH-1:0]    cnt_next;
  logic                    beat_err;
  logic                    timed_out;
  always_comb begin
    prod      = bus.mem1_output * bus.mem2_output;
    acc_next  = (bus.data_valid && cnt < VW) ? acc + RESULT_WIDTH'(prod) : acc;
    // counter parks at VECTOR_WIDTH+1 so overlong streams stay distinguishable
    cnt_next  = (bus.data_valid && cnt <= VW) ? cnt + 1'b1 : cnt;
    beat_err  = bus.data_valid && (bus.element_count != cnt || cnt >= VW);
    timed_out = timer == TW'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      acc               <= '0;
      cnt               <= '0;
      timer             <= '0;
      bus.busy          <= 1'b0;
      bus.start_reading <= 1'b0;
      bus.result        <= '0;
      bus.result_valid  <= 1'b0;
      bus.length_err    <= 1'b0;
      bus.timeout_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state             <= REQ;
          acc               <= '0;
          cnt               <= '0;
          timer             <= '0;
          bus.busy          <= 1'b1;
          bus.start_reading <= 1'b1;
          bus.length_err    <= 1'b0;
          bus.timeout_err   <= 1'b0;
        end
        REQ: begin
          state             <= ACCUM;
          bus.start_reading <= 1'b0;
        end
        ACCUM: begin
          acc   <= acc_next;
          cnt   <= cnt_next;
          timer <= timer + 1'b1;
          if (beat_err) bus.length_err <= 1'b1;
          if (bus.reading_done) begin
            state            <= DONE;
            bus.result       <= acc_next;
            bus.result_valid <= 1'b1;
            if (cnt_next != VW) bus.length_err <= 1'b1;
          end else if (timed_out) begin
            state            <= DONE;
            bus.result       <= acc_next;
            bus.result_valid <= 1'b1;
            bus.timeout_err  <= 1'b1;
          end
        end
        DONE: if (bus.result_ready) begin
          state            <= IDLE;
          bus.result_valid <= 1'b0;
          bus.busy         <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_stream_engine.sv
// tb_dot_product_stream_engine: scoreboard-driven checks of the dot product engine
module tb_dot_product_stream_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dot_product_stream_engine_if #(.DATA_WIDTH(8), .CNT_WIDTH(3), .RESULT_WIDTH(18)) bus ();
  dot_product_stream_engine #(
    .DATA_WIDTH(8), .VECTOR_WIDTH(4), .CNT_WIDTH(3), .RESULT_WIDTH(18), .TIMEOUT_CYCLES(64)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {logic [17:0] res; logic lerr; logic terr;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int sr_count = 0;
  logic [7:0] va[8];
  logic [7:0] vb[8];
  logic [2:0] vec[8];
  always @(posedge clk) if (bus.start_reading) sr_count++;
  task tick;
    @(posedge clk);
    #1;
  endtask
  task set_vecs(input int kind);
    for (int i = 0; i < 8; i++) begin
      va[i]  = kind == 0 ? 8'(i) : kind == 1 ? 8'd255 : 8'($urandom_range(0, 255));
      vb[i]  = kind == 0 ? 8'(4 - i) : kind == 1 ? 8'd255 : 8'($urandom_range(0, 255));
      vec[i] = 3'(i);
    end
    if (kind == 0) begin
      va[4] = 8'd9;
      vb[4] = 8'd9;
    end
  endtask
  function automatic logic [17:0] model_sum(input int n);
    logic [17:0] s = '0;
    for (int i = 0; i < n && i < 4; i++) s += 18'(va[i]) * 18'(vb[i]);
    return s;
  endfunction
  task launch;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
  endtask
  task beats(input int n, input bit done_last);
    for (int i = 0; i < n; i++) begin
      bus.data_valid    = 1'b1;
      bus.mem1_output   = va[i];
      bus.mem2_output   = vb[i];
      bus.element_count = vec[i];
      bus.reading_done  = done_last && i == n - 1;
      tick;
    end
    bus.data_valid   = 1'b0;
    bus.reading_done = 1'b0;
  endtask
  task collect(input string name, output int waited);
    exp_t e;
    waited = 0;
    while (!bus.result_valid && waited < 300) begin
      tick;
      waited++;
    end
    checks++;
    if (!bus.result_valid || sb.size() == 0) begin
      errors++;
      $display("FAIL %s no result: result_valid=%0b queued=%0d", name, bus.result_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (bus.result !== e.res) begin
        errors++;
        $display("FAIL %s result: got %0d expected %0d", name, bus.result, e.res);
      end
      checks++;
      if ({bus.length_err, bus.timeout_err} !== {e.lerr, e.terr}) begin
        errors++;
        $display("FAIL %s errs: got len=%0b to=%0b expected len=%0b to=%0b", name,
                 bus.length_err, bus.timeout_err, e.lerr, e.terr);
      end
    end
  endtask
  task accept(input string name);
    bus.result_ready = 1'b1;
    tick;
    bus.result_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%0b result_valid=%0b expected 0 0", name, bus.busy, bus.result_valid);
    end
  endtask
  task run_op(input string name, input int n, input logic [17:0] res, input bit lerr);
    int w;
    int sr0;
    sr0 = sr_count;
    sb.push_back('{res: res, lerr: lerr, terr: 1'b0});
    launch;
    beats(n, 1'b1);
    collect(name, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL %s latency: extra cycles %0d expected 0", name, w);
    end
    checks++;
    if (sr_count - sr0 !== 1) begin
      errors++;
      $display("FAIL %s start_reading pulses: got %0d expected 1", name, sr_count - sr0);
    end
    accept(name);
  endtask
  task test_reset;
    checks++;
    if ({bus.busy, bus.start_reading, bus.result, bus.result_valid, bus.length_err, bus.timeout_err} !== 23'd0) begin
      errors++;
      $display("FAIL reset outputs: busy=%0b sr=%0b res=%0d rv=%0b le=%0b te=%0b expected all 0",
               bus.busy, bus.start_reading, bus.result, bus.result_valid, bus.length_err, bus.timeout_err);
    end
  endtask
  task test_basic;
    set_vecs(0);
    run_op("basic", 4, 18'd10, 1'b0);
  endtask
  task test_max;
    set_vecs(1);
    run_op("max", 4, 18'd260100, 1'b0);
  endtask
  task test_random;
    for (int k = 0; k < 3; k++) begin
      set_vecs(2);
      run_op("random", 4, model_sum(4), 1'b0);
    end
  endtask
  task test_backpressure;
    int w;
    int sr0;
    logic [17:0] held;
    set_vecs(0);
    sb.push_back('{res: 18'd10, lerr: 1'b0, terr: 1'b0});
    launch;
    beats(4, 1'b1);
    collect("backpressure", w);
    held = bus.result;
    sr0 = sr_count;
    bus.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (bus.result !== held || bus.result_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure hold %0d: result=%0d rv=%0b expected %0d 1", i, bus.result, bus.result_valid, held);
      end
    end
    bus.start = 1'b0;
    accept("backpressure");
    tick;
    checks++;
    if (sr_count !== sr0 || bus.busy !== 1'b0 || bus.result !== held) begin
      errors++;
      $display("FAIL backpressure ignored start: pulses=%0d busy=%0b result=%0d expected 0 0 %0d",
               sr_count - sr0, bus.busy, bus.result, held);
    end
  endtask
  task test_length;
    set_vecs(0);
    run_op("short3", 3, model_sum(3), 1'b1);
    run_op("long5", 5, 18'd10, 1'b1);
    vec[2] = 3'd1;
    run_op("order", 4, 18'd10, 1'b1);
    vec[2] = 3'd2;
    run_op("clean_after", 4, 18'd10, 1'b0);
  endtask
  task test_timeout;
    int w;
    sb.push_back('{res: 18'd0, lerr: 1'b0, terr: 1'b1});
    launch;
    collect("timeout", w);
    checks++;
    if (w !== 64) begin
      errors++;
      $display("FAIL timeout cycles: got %0d expected 64", w);
    end
    accept("timeout");
  endtask
  task test_reset_mid;
    int sr0;
    set_vecs(0);
    launch;
    beats(2, 1'b0);
    rst_n = 1'b0;
    #1;
    test_reset;
    tick;
    tick;
    rst_n = 1'b1;
    sr0 = sr_count;
    repeat (4) tick;
    checks++;
    if (sr_count !== sr0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid release: pulses=%0d busy=%0b expected 0 0", sr_count - sr0, bus.busy);
    end
    run_op("after_reset", 4, 18'd10, 1'b0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.data_valid = 1'b0;
    bus.mem1_output = '0;
    bus.mem2_output = '0;
    bus.element_count = '0;
    bus.reading_done = 1'b0;
    bus.result_ready = 1'b0;
    #2;
    test_reset;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    test_reset;
    test_basic;
    test_max;
    test_random;
    test_backpressure;
    test_length;
    test_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
